// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier controller:
// operand width, iteration count, RV32M op encodings and FSM states.
package mul_pkg;

  localparam int XLEN      = 32;
  localparam int MUL_ITERS = 32;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ABS_A  = 3'd1,
    ST_ABS_B  = 3'd2,
    ST_MUL    = 3'd3,
    ST_NEG_LO = 3'd4,
    ST_NEG_HI = 3'd5,
    ST_DONE   = 3'd6
  } mul_state_e;

  // Operand signedness for an op, returned as {a_signed, b_signed}.
  function automatic logic [1:0] op_signs(input logic [1:0] op);
    logic [1:0] s;
    case (op)
      OP_MUL:    s = 2'b00;
      OP_MULH:   s = 2'b11;
      OP_MULHSU: s = 2'b10;
      OP_MULHU:  s = 2'b00;
      default:   s = 2'b00;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/RCA.sv
// Plain ripple-carry adder: one full adder per bit, carry chained LSB to MSB.
module RCA #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  // Ripple the carry through the full-adder chain
  always_comb begin
    logic carry_v;
    carry_v = cin;
    sum     = {W{1'b0}};
    for (int i = 0; i < W; i++) begin
      sum[i]  = a[i] ^ b[i] ^ carry_v;
      carry_v = (a[i] & b[i]) | (carry_v & (a[i] ^ b[i]));
    end
    cout = carry_v;
  end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Multi-cycle shift-add multiplier controller for RV32M MUL/MULH/MULHSU/MULHU.
// A single RCA is time-shared between operand magnitude, 32 accumulate
// iterations and final two-word negation.
// Build option: MUL_SIGNED_EN enables the signed ops (ABS_A/ABS_B/NEG_LO/
// NEG_HI states); without it every operand is unsigned and latency is 33.
module mul_seq_ctrl #(
  parameter int XLEN  = mul_pkg::XLEN,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag
);
  import mul_pkg::*;

  localparam logic [4:0] LAST_ITER = 5'(MUL_ITERS - 1);

  mul_state_e       state_r;
  logic [1:0]       op_r;
  logic [XLEN-1:0]  m_r;       // multiplicand (|a| once ABS_A is done)
  logic [XLEN-1:0]  p_hi_r;    // accumulator high word
  logic [XLEN-1:0]  p_lo_r;    // multiplier, shifted out as product bits shift in
  logic [4:0]       cnt_r;
  logic [TAG_W-1:0] tag_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [XLEN-1:0]  out_result_r;
  logic [TAG_W-1:0] out_tag_r;
`ifdef MUL_SIGNED_EN
  logic             sa_r;      // a is signed and negative
  logic             sb_r;      // b is signed and negative
  logic             neg_r;     // final product must be negated
  logic             carry_r;   // carry from low-word negation into high word
  logic [1:0]       signs_s;
`endif

  logic [XLEN-1:0]  add_a_s;
  logic [XLEN-1:0]  add_b_s;
  logic             add_cin_s;
  logic [XLEN-1:0]  add_sum_s;
  logic             add_cout_s;
  logic [XLEN-1:0]  p_hi_nxt_s;
  logic [XLEN-1:0]  p_lo_nxt_s;
  logic [XLEN-1:0]  result_nxt_s;

`ifdef MUL_SIGNED_EN
  assign signs_s = op_signs(in_op);
`endif

  RCA #(.W(XLEN)) u_rca (
    .a    (add_a_s),
    .b    (add_b_s),
    .cin  (add_cin_s),
    .sum  (add_sum_s),
    .cout (add_cout_s)
  );

  // Steer the shared adder: each active state owns it, all others drive zeros
  always_comb begin
    add_a_s   = {XLEN{1'b0}};
    add_b_s   = {XLEN{1'b0}};
    add_cin_s = 1'b0;
    case (state_r)
`ifdef MUL_SIGNED_EN
      ST_ABS_A: begin
        if (sa_r) begin
          add_a_s   = ~m_r;
          add_cin_s = 1'b1;
        end else begin
          add_a_s   = {XLEN{1'b0}};
          add_cin_s = 1'b0;
        end
      end
      ST_ABS_B: begin
        if (sb_r) begin
          add_a_s   = ~p_lo_r;
          add_cin_s = 1'b1;
        end else begin
          add_a_s   = {XLEN{1'b0}};
          add_cin_s = 1'b0;
        end
      end
      ST_NEG_LO: begin
        if (neg_r) begin
          add_a_s   = ~p_lo_r;
          add_cin_s = 1'b1;
        end else begin
          add_a_s   = {XLEN{1'b0}};
          add_cin_s = 1'b0;
        end
      end
      ST_NEG_HI: begin
        if (neg_r) begin
          add_a_s   = ~p_hi_r;
          add_cin_s = carry_r;
        end else begin
          add_a_s   = {XLEN{1'b0}};
          add_cin_s = 1'b0;
        end
      end
`endif
      ST_MUL: begin
        add_a_s = p_hi_r;
        if (p_lo_r[0]) begin
          add_b_s = m_r;
        end else begin
          add_b_s = {XLEN{1'b0}};
        end
      end
      default: begin
        add_a_s   = {XLEN{1'b0}};
        add_b_s   = {XLEN{1'b0}};
        add_cin_s = 1'b0;
      end
    endcase
  end

  // Next accumulator words and the result word picked for the op
  always_comb begin
    p_hi_nxt_s = p_hi_r;
    p_lo_nxt_s = p_lo_r;
    case (state_r)
      ST_MUL: begin
        p_hi_nxt_s = {add_cout_s, add_sum_s[XLEN-1:1]};
        p_lo_nxt_s = {add_sum_s[0], p_lo_r[XLEN-1:1]};
      end
`ifdef MUL_SIGNED_EN
      ST_NEG_LO: begin
        if (neg_r) begin
          p_lo_nxt_s = add_sum_s;
        end else begin
          p_lo_nxt_s = p_lo_r;
        end
      end
      ST_NEG_HI: begin
        if (neg_r) begin
          p_hi_nxt_s = add_sum_s;
        end else begin
          p_hi_nxt_s = p_hi_r;
        end
      end
`endif
      default: begin
        p_hi_nxt_s = p_hi_r;
        p_lo_nxt_s = p_lo_r;
      end
    endcase
    if (op_r == OP_MUL) begin
      result_nxt_s = p_lo_nxt_s;
    end else begin
      result_nxt_s = p_hi_nxt_s;
    end
  end

  // Sequencer FSM with datapath registers and registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      op_r         <= 2'b00;
      m_r          <= {XLEN{1'b0}};
      p_hi_r       <= {XLEN{1'b0}};
      p_lo_r       <= {XLEN{1'b0}};
      cnt_r        <= 5'd0;
      tag_r        <= {TAG_W{1'b0}};
      in_ready_r   <= 1'b1;
      out_valid_r  <= 1'b0;
      out_result_r <= {XLEN{1'b0}};
      out_tag_r    <= {TAG_W{1'b0}};
`ifdef MUL_SIGNED_EN
      sa_r         <= 1'b0;
      sb_r         <= 1'b0;
      neg_r        <= 1'b0;
      carry_r      <= 1'b0;
`endif
    end else if (flush) begin
      // Abort anything in flight; in DONE this also completes a pending transfer
      state_r     <= ST_IDLE;
      cnt_r       <= 5'd0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            op_r       <= in_op;
            m_r        <= in_a;
            p_lo_r     <= in_b;
            p_hi_r     <= {XLEN{1'b0}};
            tag_r      <= in_tag;
            cnt_r      <= 5'd0;
            in_ready_r <= 1'b0;
`ifdef MUL_SIGNED_EN
            sa_r       <= signs_s[1] & in_a[XLEN-1];
            sb_r       <= signs_s[0] & in_b[XLEN-1];
            neg_r      <= (signs_s[1] & in_a[XLEN-1]) ^ (signs_s[0] & in_b[XLEN-1]);
            state_r    <= ST_ABS_A;
`else
            state_r    <= ST_MUL;
`endif
          end
        end
`ifdef MUL_SIGNED_EN
        ST_ABS_A: begin
          if (sa_r) begin
            m_r <= add_sum_s;
          end
          state_r <= ST_ABS_B;
        end
        ST_ABS_B: begin
          if (sb_r) begin
            p_lo_r <= add_sum_s;
          end
          state_r <= ST_MUL;
        end
`endif
        ST_MUL: begin
          p_hi_r <= p_hi_nxt_s;
          p_lo_r <= p_lo_nxt_s;
          cnt_r  <= cnt_r + 5'd1;
          if (cnt_r == LAST_ITER) begin
`ifdef MUL_SIGNED_EN
            state_r      <= ST_NEG_LO;
`else
            state_r      <= ST_DONE;
            out_valid_r  <= 1'b1;
            out_result_r <= result_nxt_s;
            out_tag_r    <= tag_r;
`endif
          end
        end
`ifdef MUL_SIGNED_EN
        ST_NEG_LO: begin
          p_lo_r  <= p_lo_nxt_s;
          carry_r <= add_cout_s;
          state_r <= ST_NEG_HI;
        end
        ST_NEG_HI: begin
          p_hi_r       <= p_hi_nxt_s;
          state_r      <= ST_DONE;
          out_valid_r  <= 1'b1;
          out_result_r <= result_nxt_s;
          out_tag_r    <= tag_r;
        end
`endif
        ST_DONE: begin
          if (out_ready) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign out_result = out_result_r;
  assign out_tag    = out_tag_r;

endmodule

// File: doc/mul_seq_ctrl.md
# mul_seq_ctrl

Multi-cycle shift-add multiplier controller for the RV32M MUL/MULH/MULHSU/MULHU instructions. It sequences a single 32-bit ripple-carry adder (`RCA`) over 32 accumulate iterations, plus optional operand-magnitude and result-negation passes. It sits beside the EX-stage ALU, accepts one operation at a time through a valid/ready handshake and returns a 32-bit result with its writeback tag. The pipeline can flush it at any time.

## Interface
- `XLEN`, default 32, operand/result width; only 32 is supported.
- `TAG_W`, default 5, width of the destination-register tag that passes through.
- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — asynchronous, active-high reset.
- `in_valid` in 1 — operation request.
- `in_ready` out 1 — controller is in IDLE and can accept.
- `in_op` in 2 — 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- `in_a` in 32 — rs1 operand (multiplicand).
- `in_b` in 32 — rs2 operand (multiplier).
- `in_tag` in TAG_W — destination tag.
- `flush` in 1 — abort the current operation.
- `out_valid` out 1 — result available.
- `out_ready` in 1 — consumer accepts the result.
- `out_result` out 32 — result: low word for MUL, high word otherwise.
- `out_tag` out TAG_W — tag of the result.

## Operation
- **Accept:** accept occurs when `in_valid & in_ready & ~flush`. Op, operands and tag are latched.
- **Signedness:**
  - `a` is signed for MULH and MULHSU.
  - `b` is signed for MULH only.
  - `neg = sa ^ sb`, where `sa`/`sb` are the operand sign bits of the signed operands.
- **States:**
  - IDLE → ABS_A on accept.
  - ABS_A → ABS_B → MUL.
  - MUL holds for 32 iterations; a 5-bit counter runs 0..31, and the last iteration goes to NEG_LO.
  - NEG_LO → NEG_HI → DONE.
  - DONE → IDLE when `out_ready`.
- **ABS_x:** if operand x is signed and negative, the adder computes `~x + 0 + cin=1` and the register takes the result. Otherwise the register is unchanged. The cycle is spent either way, so latency is fixed.
- **MUL iteration** (accumulator P_hi = 0, P_lo = |b|, M = |a|):
  - If `P_lo[0]`, the adder computes `P_hi + M` (cin 0); otherwise `P_hi + 0`.
  - Then `{P_hi, P_lo} <= {cout, sum, P_lo} >> 1`.
- **NEG_LO:** if `neg`, adder computes `~P_lo + 0 + 1`; the carry is saved.
- **NEG_HI:** if `neg`, adder computes `~P_hi + 0 + saved carry`.
- **Shared adder:** the only adder in the block is the single `RCA` instance. Its a/b/cin inputs are muxed by state. Outside the active states its inputs are driven to 0.
- **Magnitude of 0x80000000:** it stays 0x80000000 and is treated as unsigned 2^31; the product is correct.
- **Flush:**
  - `flush` in any state → IDLE on the next edge; `out_valid` drops.
  - `flush` wins over `in_valid` in the same cycle.
  - In DONE with `out_ready` and `flush` both high, the transfer completes and the state goes to IDLE.
- **Output stability:** `out_result`/`out_tag` are registered and remain stable while `out_valid & ~out_ready`.

## Timing
- Accept edge at cycle T:
  - ABS_A occupies T+1 and ABS_B T+2.
  - MUL occupies T+3..T+34.
  - NEG_LO occupies T+35 and NEG_HI T+36.
  - `out_valid` is high from T+37.
- **Fixed latency:** 37 cycles with `MUL_SIGNED_EN`, 33 without.
- **Back-to-back:** `in_ready` goes high in the cycle after the result transfer. Minimum issue interval is latency + 1.
- **Reset values:**
  - state IDLE, `in_ready` 1, `out_valid` 0, `out_result` 0, `out_tag` 0.
  - counters 0 and internal registers 0.
- **Reset mid-operation:** takes effect immediately; no output is produced.

## Configuration
- **`MUL_SIGNED_EN` defined:** full behaviour as above, covering all four ops and the ABS/NEG states.
- **`MUL_SIGNED_EN` undefined:**
  - ABS_A, ABS_B, NEG_LO and NEG_HI are not compiled; states run IDLE → MUL → DONE.
  - All operands are treated as unsigned, so MULH and MULHSU return the MULHU result.
  - MUL remains correct.
  - Latency is 33.

## Structure
- **Shared package `mul_pkg`:**
  - op encoding constants: `OP_MUL`, `OP_MULH`, `OP_MULHSU`, `OP_MULHU`.
  - state enum.
  - `XLEN`.
  - `MUL_ITERS` = 32.
- **Sub-module:** exactly one instance of the existing 32-bit `RCA` (a, b, cin, sum, cout). No other adders or `*` operators are allowed.

## Test plan
- **MULHU:** a=0xFFFFFFFF, b=0xFFFFFFFF → `out_result`=0xFFFFFFFE; `out_valid` at exactly T+37 (T+33 without the macro).
- **MUL / MULH:** a=0xFFFFFFFD (−3), b=7.
  - MUL → 0xFFFFFFEB.
  - MULH → 0xFFFFFFFF.
  - MULHU → 0x00000006.
- **MULH of 0x80000000 × 0x80000000** → 0x40000000; MULHSU of the same operands → 0xC0000000.
- **Zero and tag passthrough:** a=0 with any b → 0 for all ops; tag 0x1F passes through to `out_tag`.
- **Backpressure:** `out_ready` held low for 5 cycles after `out_valid` → result and tag stable and `in_ready` low; the transfer on the 6th cycle is followed by `in_ready`=1 in the next cycle.
- **Flush and reset:**
  - `flush` during MUL iteration 10 → IDLE next cycle with no `out_valid`; a new op accepted afterwards gives the correct result.
  - `flush` together with `in_valid` in IDLE → no accept.
  - Asynchronous `rst` pulse mid-op → all outputs at reset values immediately.
